// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit sitting between EXU and WBU.
//   in_*      : EXU result handshake; in_exu_result is the effective address
//               for loads/stores and the rd value for everything else.
//   mem_req_* : one outstanding request at a time; address is 8-byte aligned,
//               store data and byte mask are shifted to the addressed lane.
//   mem_rsp_* : single-cycle response/ack carrying a full 64-bit beat.
//   out_*     : registered result to WBU, held until out_ready.
//   out_misalign flags a misaligned access; no bus request is made for it.
module ysyx_22040237_lsu #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_exu_result,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [RIDX_W-1:0] in_rd_idx,
  input  logic              in_rd_wen,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [RIDX_W-1:0] out_rd_idx,
  output logic              out_rd_wen,
  output logic [XLEN-1:0]   out_rd_data,
  output logic              out_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]     sdata_q, sdata_d;
  logic [XLEN-1:0]     rd_data_q, rd_data_d;
  logic [RIDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                rd_wen_q, rd_wen_d;
  logic                is_load_q, is_load_d;
  logic                is_store_q, is_store_d;
  logic                misalign_q, misalign_d;

  logic                in_misalign;
  logic [7:0]          base_mask;
  logic [5:0]          lane_shift;
  logic [XLEN-1:0]     rsp_shifted;
  logic [XLEN-1:0]     load_ext;

  // funct3[1:0] encodes the access size for every funct3 value, including 111.
  always_comb begin
    case (in_funct3[1:0])
      2'b00:   in_misalign = 1'b0;
      2'b01:   in_misalign = in_exu_result[0];
      2'b10:   in_misalign = |in_exu_result[1:0];
      default: in_misalign = |in_exu_result[2:0];
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      2'b10:   base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  assign lane_shift  = {addr_q[2:0], 3'b000};
  assign rsp_shifted = mem_rsp_rdata >> lane_shift;

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){rsp_shifted[7]}},   rsp_shifted[7:0]};
      3'b001:  load_ext = {{(XLEN-16){rsp_shifted[15]}}, rsp_shifted[15:0]};
      3'b010:  load_ext = {{(XLEN-32){rsp_shifted[31]}}, rsp_shifted[31:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}},  rsp_shifted[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, rsp_shifted[15:0]};
      3'b110:  load_ext = {{(XLEN-32){1'b0}}, rsp_shifted[31:0]};
      default: load_ext = rsp_shifted;
    endcase
  end

  // Request fields are derived from latched state, so they stay stable for
  // as long as the request is stalled.
  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = mem_req_valid ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem_req_wen   = mem_req_valid & is_store_q;
  assign mem_req_wdata = mem_req_valid ? (sdata_q << lane_shift) : '0;
  assign mem_req_wmask = mem_req_valid ? (base_mask << addr_q[2:0]) : '0;

  assign out_valid    = (state_q == S_DONE);
  assign out_pc       = pc_q;
  assign out_rd_idx   = rd_idx_q;
  assign out_rd_wen   = rd_wen_q;
  assign out_rd_data  = rd_data_q;
  assign out_misalign = misalign_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    rd_data_d  = rd_data_q;
    rd_idx_d   = rd_idx_q;
    funct3_d   = funct3_q;
    rd_wen_d   = rd_wen_q;
    is_load_d  = is_load_q;
    is_store_d = is_store_q;
    misalign_d = misalign_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pc_d       = in_pc;
          addr_d     = in_exu_result;
          sdata_d    = in_store_data;
          rd_idx_d   = in_rd_idx;
          funct3_d   = in_funct3;
          is_load_d  = in_is_load;
          is_store_d = in_is_store;
          rd_wen_d   = in_rd_wen;
          rd_data_d  = '0;
          misalign_d = 1'b0;
          if (!(in_is_load || in_is_store)) begin
            rd_data_d = in_exu_result;
            state_d   = S_DONE;
          end else if (in_misalign) begin
            misalign_d = 1'b1;
            rd_wen_d   = 1'b0;
            state_d    = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          rd_data_d = is_load_q ? load_ext : '0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      addr_q     <= '0;
      sdata_q    <= '0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      funct3_q   <= '0;
      rd_wen_q   <= 1'b0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      rd_data_q  <= rd_data_d;
      rd_idx_q   <= rd_idx_d;
      funct3_q   <= funct3_d;
      rd_wen_q   <= rd_wen_d;
      is_load_q  <= is_load_d;
      is_store_q <= is_store_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
